// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: shared op encoding, bit indices and saturation limits
// for the dsp_mac_pipe multiply-accumulate slice.
package dsp_mac_pkg;

  localparam int OP_PREADD_EN  = 0;
  localparam int OP_PREADD_SUB = 1;
  localparam int OP_FIRST      = 2;
  localparam int OP_ACC_SUB    = 3;
  localparam int OP_W          = 4;

  localparam int SAT_W = 128;

  typedef struct packed {
    logic acc_sub;
    logic first;
    logic preadd_sub;
    logic preadd_en;
  } op_t;

  // Limits for a w-bit signed value, returned in the low w bits.
  function automatic logic [SAT_W-1:0] sat_max(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/dsp_mac_if.sv
// dsp_mac_if: input beat stream (valid/ready, ch, a, b, d, op, last) and
// result stream (valid/ready, ch, p, ovf); slave = MAC, master = source/sink.
interface dsp_mac_if #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  import dsp_mac_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [CH_W-1:0]             in_ch;
  logic signed [A_WIDTH-1:0]   in_a;
  logic signed [B_WIDTH-1:0]   in_b;
  logic signed [B_WIDTH-1:0]   in_d;
  op_t                         in_op;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [CH_W-1:0]             out_ch;
  logic signed [ACC_WIDTH-1:0] out_p;
  logic                        out_ovf;

  modport master (
    output in_valid, in_ch, in_a, in_b, in_d, in_op, in_last,
    input  in_ready,
    input  out_valid, out_ch, out_p, out_ovf,
    output out_ready
  );

  modport slave (
    input  in_valid, in_ch, in_a, in_b, in_d, in_op, in_last,
    output in_ready,
    output out_valid, out_ch, out_p, out_ovf,
    input  out_ready
  );

endinterface

// File: rtl/dsp_mac_preadd.sv
// dsp_mac_preadd: registered signed pre-adder stage, bp = b, d+b or d-b.
// Ports: clk, rst_n, en (advance), vld_i/vld_o, pre_en, pre_sub, b_i, d_i, bp_o.
module dsp_mac_preadd #(
  parameter int B_WIDTH = 18
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      vld_i,
  input  logic                      pre_en,
  input  logic                      pre_sub,
  input  logic signed [B_WIDTH-1:0] b_i,
  input  logic signed [B_WIDTH-1:0] d_i,
  output logic                      vld_o,
  output logic signed [B_WIDTH:0]   bp_o
);
  localparam int BW1 = B_WIDTH + 1;

  logic                  vld_q, vld_d;
  logic signed [BW1-1:0] bp_q, bp_d;
  logic signed [BW1-1:0] b_x, d_x;

  always_comb begin
    b_x   = BW1'(b_i);
    d_x   = BW1'(d_i);
    vld_d = vld_q;
    bp_d  = bp_q;
    if (en) begin
      vld_d = vld_i;
      if (vld_i) begin
        unique case (1'b1)
          !pre_en:           bp_d = b_x;
          pre_en && !pre_sub: bp_d = d_x + b_x;
          pre_en && pre_sub:  bp_d = d_x - b_x;
          default:           bp_d = b_x;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      bp_q  <= '0;
    end else begin
      vld_q <= vld_d;
      bp_q  <= bp_d;
    end
  end

  assign vld_o = vld_q;
  assign bp_o  = bp_q;

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: multi-channel signed MAC, stages in/preadd/mult/acc/out.
// Ports: clk, rst_n, bus (dsp_mac_if.slave); DSP_MAC_SATURATE_EN clamps acc.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic       clk,
  input logic       rst_n,
  dsp_mac_if.slave  bus
);
  localparam int PW = A_WIDTH + B_WIDTH + 1;
  localparam int AW = ACC_WIDTH;
  localparam logic [SAT_W-1:0] SMAX_W = sat_max(AW);
  localparam logic [SAT_W-1:0] SMIN_W = sat_min(AW);
  localparam logic [AW-1:0]    SMAX   = SMAX_W[AW-1:0];
  localparam logic [AW-1:0]    SMIN   = SMIN_W[AW-1:0];

  // Assert asynchronously, release on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_ni     = rst_sync_q[1];

  logic adv;

  logic                        s1_vld_q, s1_vld_d;
  logic [CH_W-1:0]             s1_ch_q, s1_ch_d;
  logic signed [A_WIDTH-1:0]   s1_a_q, s1_a_d;
  logic signed [B_WIDTH-1:0]   s1_b_q, s1_b_d;
  logic signed [B_WIDTH-1:0]   s1_d_q, s1_d_d;
  op_t                         s1_op_q, s1_op_d;
  logic                        s1_last_q, s1_last_d;

  logic                        s2_vld;
  logic signed [B_WIDTH:0]     s2_bp;
  logic [CH_W-1:0]             s2_ch_q, s2_ch_d;
  logic signed [A_WIDTH-1:0]   s2_a_q, s2_a_d;
  logic                        s2_first_q, s2_first_d;
  logic                        s2_asub_q, s2_asub_d;
  logic                        s2_last_q, s2_last_d;

  logic                        s3_vld_q, s3_vld_d;
  logic [CH_W-1:0]             s3_ch_q, s3_ch_d;
  logic signed [PW-1:0]        s3_m_q, s3_m_d;
  logic                        s3_first_q, s3_first_d;
  logic                        s3_asub_q, s3_asub_d;
  logic                        s3_last_q, s3_last_d;

  logic                        r_vld_q, r_vld_d;
  logic [CH_W-1:0]             r_ch_q, r_ch_d;
  logic signed [AW-1:0]        r_p_q, r_p_d;
  logic                        r_ovf_q, r_ovf_d;

  logic                        out_vld_q, out_vld_d;
  logic [CH_W-1:0]             out_ch_q, out_ch_d;
  logic signed [AW-1:0]        out_p_q, out_p_d;
  logic                        out_ovf_q, out_ovf_d;

  logic signed [AW-1:0]        acc_q [NUM_CH];
  logic signed [AW-1:0]        acc_d [NUM_CH];
  logic [NUM_CH-1:0]           ovf_q, ovf_d;

  logic signed [AW-1:0]        mx, base, acc_new;
  logic [AW:0]                 sum_x;
  logic                        ovf_now, ovf_new;

  assign adv = !out_vld_q || bus.out_ready;

  dsp_mac_preadd #(.B_WIDTH(B_WIDTH)) u_preadd (
    .clk     (clk),
    .rst_n   (rst_ni),
    .en      (adv),
    .vld_i   (s1_vld_q),
    .pre_en  (s1_op_q.preadd_en),
    .pre_sub (s1_op_q.preadd_sub),
    .b_i     (s1_b_q),
    .d_i     (s1_d_q),
    .vld_o   (s2_vld),
    .bp_o    (s2_bp)
  );

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_ch_d    = s1_ch_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_d_d     = s1_d_q;
    s1_op_d    = s1_op_q;
    s1_last_d  = s1_last_q;
    s2_ch_d    = s2_ch_q;
    s2_a_d     = s2_a_q;
    s2_first_d = s2_first_q;
    s2_asub_d  = s2_asub_q;
    s2_last_d  = s2_last_q;
    s3_vld_d   = s3_vld_q;
    s3_ch_d    = s3_ch_q;
    s3_m_d     = s3_m_q;
    s3_first_d = s3_first_q;
    s3_asub_d  = s3_asub_q;
    s3_last_d  = s3_last_q;
    r_vld_d    = r_vld_q;
    r_ch_d     = r_ch_q;
    r_p_d      = r_p_q;
    r_ovf_d    = r_ovf_q;
    out_vld_d  = out_vld_q;
    out_ch_d   = out_ch_q;
    out_p_d    = out_p_q;
    out_ovf_d  = out_ovf_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;

    // One extra bit exposes signed overflow of the AW-bit add/sub.
    mx      = AW'(s3_m_q);
    base    = s3_first_q ? '0 : acc_q[s3_ch_q];
    sum_x   = s3_asub_q ? {base[AW-1], base} - {mx[AW-1], mx}
                        : {base[AW-1], base} + {mx[AW-1], mx};
    ovf_now = sum_x[AW] ^ sum_x[AW-1];
    acc_new = sum_x[AW-1:0];
`ifdef DSP_MAC_SATURATE_EN
    if (ovf_now) acc_new = sum_x[AW] ? SMIN : SMAX;
`endif
    ovf_new = (!s3_first_q && ovf_q[s3_ch_q]) || ovf_now;

    if (adv) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_ch_d   = bus.in_ch;
        s1_a_d    = bus.in_a;
        s1_b_d    = bus.in_b;
        s1_d_d    = bus.in_d;
        s1_op_d   = bus.in_op;
        s1_last_d = bus.in_last;
      end
      if (s1_vld_q) begin
        s2_ch_d    = s1_ch_q;
        s2_a_d     = s1_a_q;
        s2_first_d = s1_op_q.first;
        s2_asub_d  = s1_op_q.acc_sub;
        s2_last_d  = s1_last_q;
      end
      s3_vld_d = s2_vld;
      if (s2_vld) begin
        s3_ch_d    = s2_ch_q;
        s3_m_d     = PW'(s2_a_q) * PW'(s2_bp);
        s3_first_d = s2_first_q;
        s3_asub_d  = s2_asub_q;
        s3_last_d  = s2_last_q;
      end
      r_vld_d = s3_vld_q && s3_last_q;
      if (s3_vld_q) begin
        acc_d[s3_ch_q] = acc_new;
        ovf_d[s3_ch_q] = ovf_new;
        if (s3_last_q) begin
          r_ch_d  = s3_ch_q;
          r_p_d   = acc_new;
          r_ovf_d = ovf_new;
        end
      end
      out_vld_d = r_vld_q;
      if (r_vld_q) begin
        out_ch_d  = r_ch_q;
        out_p_d   = r_p_q;
        out_ovf_d = r_ovf_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_d_q     <= '0;
      s1_op_q    <= '0;
      s1_last_q  <= 1'b0;
      s2_ch_q    <= '0;
      s2_a_q     <= '0;
      s2_first_q <= 1'b0;
      s2_asub_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      s3_vld_q   <= 1'b0;
      s3_ch_q    <= '0;
      s3_m_q     <= '0;
      s3_first_q <= 1'b0;
      s3_asub_q  <= 1'b0;
      s3_last_q  <= 1'b0;
      r_vld_q    <= 1'b0;
      r_ch_q     <= '0;
      r_p_q      <= '0;
      r_ovf_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_ch_q   <= '0;
      out_p_q    <= '0;
      out_ovf_q  <= 1'b0;
      acc_q      <= '{default: '0};
      ovf_q      <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_ch_q    <= s1_ch_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_d_q     <= s1_d_d;
      s1_op_q    <= s1_op_d;
      s1_last_q  <= s1_last_d;
      s2_ch_q    <= s2_ch_d;
      s2_a_q     <= s2_a_d;
      s2_first_q <= s2_first_d;
      s2_asub_q  <= s2_asub_d;
      s2_last_q  <= s2_last_d;
      s3_vld_q   <= s3_vld_d;
      s3_ch_q    <= s3_ch_d;
      s3_m_q     <= s3_m_d;
      s3_first_q <= s3_first_d;
      s3_asub_q  <= s3_asub_d;
      s3_last_q  <= s3_last_d;
      r_vld_q    <= r_vld_d;
      r_ch_q     <= r_ch_d;
      r_p_q      <= r_p_d;
      r_ovf_q    <= r_ovf_d;
      out_vld_q  <= out_vld_d;
      out_ch_q   <= out_ch_d;
      out_p_q    <= out_p_d;
      out_ovf_q  <= out_ovf_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_vld_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_p     = out_p_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed beats, expected results queued at issue and
// popped by a monitor on every output handshake.
module tb_dsp_mac_pipe;
  import dsp_mac_pkg::*;

  localparam logic [3:0] PE = 4'b0001;
  localparam logic [3:0] PS = 4'b0010;
  localparam logic [3:0] FI = 4'b0100;
  localparam logic [3:0] AS = 4'b1000;

  typedef struct {
    int     ch;
    longint p;
    int     ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dsp_mac_if bus ();

  dsp_mac_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input longint act, input longint want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  task automatic push(input int ch, input longint p, input int ovf);
    exp_t e;
    e.ch  = ch;
    e.p   = p;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer.
  task automatic send(input int ch, input int a, input int b, input int d,
                      input logic [3:0] op, input bit last);
    int t;
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'(ch);
    bus.in_a     = 18'(a);
    bus.in_b     = 18'(b);
    bus.in_d     = 18'(d);
    bus.in_op    = op;
    bus.in_last  = last;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready=0 for %0d cycles, want 1", t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0",
               exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got ch=%0d p=%0d, want none",
                 bus.out_ch, bus.out_p);
      end else begin
        e = exp_q.pop_front();
        chk("res_ch", longint'(bus.out_ch), longint'(e.ch));
        chk("res_p", longint'(bus.out_p), e.p);
        chk("res_ovf", longint'(bus.out_ovf), longint'(e.ovf));
      end
    end
  end

  longint big;
  longint big_next;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_d      = '0;
    bus.in_op     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

`ifdef DSP_MAC_SATURATE_EN
    big      = (longint'(1) << 47) - 1;
    big_next = (longint'(1) << 47) - 2;
`else
    big      = -(longint'(1) << 47);
    big_next = (longint'(1) << 47) - 1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_p", longint'(bus.out_p), 0);
    chk("rst_out_ch", longint'(bus.out_ch), 0);
    chk("rst_out_ovf", longint'(bus.out_ovf), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single MAC and latency
    push(0, 15, 0);
    send(0, 3, 5, 0, FI, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("lat_k3_valid", longint'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_k4_valid", longint'(bus.out_valid), 1);
    wait_empty();

    // Pre-adder subtract and add
    push(0, -12, 0);
    send(0, -2, 4, 10, PE | PS | FI, 1'b1);
    push(1, 14, 0);
    send(1, 7, -3, 5, PE | FI, 1'b1);
    idle();
    wait_empty();

    // Interleaved channels, back-to-back
    push(0, 5, 0);
    push(1, 10, 0);
    send(0, 2, 2, 0, FI, 1'b0);
    send(1, 3, 3, 0, FI, 1'b0);
    send(0, 1, 1, 0, 4'b0000, 1'b1);
    send(1, 1, -1, 0, AS, 1'b1);
    idle();
    wait_empty();

    // Backpressure with three results in flight
    bus.out_ready = 1'b0;
    push(2, 6, 0);
    send(2, 2, 3, 0, FI, 1'b1);
    push(2, -20, 0);
    send(2, 4, 5, 0, FI | AS, 1'b1);
    push(2, -21, 0);
    send(2, -7, 3, 0, FI, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_in_ready", longint'(bus.in_ready), 0);
    chk("bp_out_valid", longint'(bus.out_valid), 1);
    chk("bp_hold_p", longint'(bus.out_p), 6);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_p2", longint'(bus.out_p), 6);
    chk("bp_hold_ch", longint'(bus.out_ch), 2);
    bus.out_ready = 1'b1;
    wait_empty();

    // Overflow: 4096 beats of 2^35 reach exactly 2^47
    for (int i = 0; i < 4096; i++) begin
      send(3, -131072, -131072, -131072, (i == 0) ? (PE | FI) : PE,
           (i == 4095));
    end
    push(3, big, 1);
    push(3, big_next, 1);
    send(3, -1, 1, 0, 4'b0000, 1'b1);
    push(3, 1, 0);
    send(3, 1, 1, 0, FI, 1'b1);
    idle();
    wait_empty();

    // Async reset with beats in flight
    send(2, 100, 1, 0, FI, 1'b0);
    push(3, big, 1);
    send(3, -131072, -131072, -131072, PE | FI, 1'b0);
    for (int i = 0; i < 4095; i++) begin
      send(3, -131072, -131072, -131072, PE, (i == 4094));
    end
    idle();
    wait_empty();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1, i + 2, 3, 0, FI, 1'b1);
    end
    idle();
    @(posedge clk);
    #1;
    chk("pre_rst_valid", longint'(bus.out_valid), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", longint'(bus.out_valid), 0);
    chk("arst_out_p", longint'(bus.out_p), 0);
    chk("arst_out_ch", longint'(bus.out_ch), 0);
    chk("arst_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    push(2, 1, 0);
    send(2, 1, 1, 0, 4'b0000, 1'b1);
    push(3, 0, 0);
    send(3, 0, 0, 0, 4'b0000, 1'b1);
    push(0, 15, 0);
    send(0, 3, 5, 0, FI, 1'b1);
    idle();
    wait_empty();
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
